// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, run-control
// states, the "all LEDs off" decoder code and the mode-cycling order.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Decoder code that lights no LED.
  localparam logic [3:0] KEY_OFF = 4'd14;

  // Mode-button order: SHL -> SHR -> BOUNCE -> BLINK -> SHL.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_SHL:    return MODE_SHR;
      MODE_SHR:    return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_BLINK;
      default:     return MODE_SHL;
    endcase
  endfunction

endpackage

// File: rtl/led_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-time debouncer and
// rising-edge pulse generator.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn        : raw active-high button, asynchronous to clk
//   pulse      : one-cycle pulse per debounced press
module led_btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [1:0]    valid;
  logic          level;
  logic          armed;
  logic [CW-1:0] cnt;

  // valid marks when sync[1] holds a real post-reset sample; armed then
  // requires the button to have been seen released, so a button held
  // through reset release cannot produce a press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      valid <= '0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      valid <= {valid[0], 1'b1};
      pulse <= 1'b0;
      if (valid[1] && !sync[1]) armed <= 1'b1;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1] & armed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED chaser controller: run/pause FSM, speed-selectable step prescaler
// and shift/bounce/blink pattern generator driving an 8-LED decoder.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   btn_run, btn_mode : raw pushbuttons (run/pause, pattern select)
//   sw_speed          : step rate, period = TICK_DIV * {8,4,2,1}
//   key               : registered decoder code, 0-7 or KEY_OFF
//   mode              : current pattern mode
//   running           : high while stepping
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic [1:0] sw_speed,
  output logic [3:0] key,
  output logic [1:0] mode,
  output logic       running
);

  import led_seq_pkg::*;

  localparam int unsigned PW = $clog2(TICK_DIV * 8);
  localparam logic [PW-1:0] TERM_X8 = PW'(TICK_DIV * 8 - 1);
  localparam logic [PW-1:0] TERM_X4 = PW'(TICK_DIV * 4 - 1);
  localparam logic [PW-1:0] TERM_X2 = PW'(TICK_DIV * 2 - 1);
  localparam logic [PW-1:0] TERM_X1 = PW'(TICK_DIV - 1);

  logic          run_p;
  logic          mode_p;
  state_t        state;
  mode_t         mode_q;
  mode_t         mode_nx;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] term;
  logic          tick;
  logic [2:0]    pos;
  logic          dir_up;
  logic          blink_on;

  led_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_run),
    .pulse (run_p)
  );

  led_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  always_comb begin
    case (sw_speed)
      2'd0:    term = TERM_X8;
      2'd1:    term = TERM_X4;
      2'd2:    term = TERM_X2;
      default: term = TERM_X1;
    endcase
  end

  // >= rather than == so a shorter period selected mid-count fires at once.
  assign tick    = (state == ST_RUN) && (pcnt >= term);
  assign mode_nx = next_mode(mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (run_p) begin
      case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   state <= ST_PAUSE;
        ST_PAUSE: state <= ST_RUN;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (state == ST_IDLE && run_p) begin
      pcnt <= '0;
    end else if (state == ST_RUN) begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  // Tick stepping uses the mode in force before any coincident mode press;
  // the mode-press assignments come last so they override phase and dir.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_SHL;
      pos      <= '0;
      dir_up   <= 1'b1;
      blink_on <= 1'b1;
    end else begin
      if (state == ST_IDLE && run_p) begin
        pos      <= '0;
        dir_up   <= 1'b1;
        blink_on <= 1'b1;
      end else if (tick) begin
        case (mode_q)
          MODE_SHL: pos <= pos + 3'd1;
          MODE_SHR: pos <= pos - 3'd1;
          MODE_BOUNCE: begin
            if (dir_up) begin
              if (pos == 3'd7) begin
                dir_up <= 1'b0;
                pos    <= 3'd6;
              end else begin
                pos <= pos + 3'd1;
              end
            end else begin
              if (pos == 3'd0) begin
                dir_up <= 1'b1;
                pos    <= 3'd1;
              end else begin
                pos <= pos - 3'd1;
              end
            end
          end
          default: blink_on <= ~blink_on;
        endcase
      end
      if (mode_p) begin
        mode_q   <= mode_nx;
        blink_on <= 1'b1;
        if (mode_nx == MODE_SHL) dir_up <= 1'b1;
        if (mode_nx == MODE_SHR) dir_up <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key <= KEY_OFF;
    end else if (state == ST_IDLE) begin
      key <= KEY_OFF;
    end else if (mode_q == MODE_BLINK && !blink_on) begin
      key <= KEY_OFF;
    end else begin
      key <= {1'b0, pos};
    end
  end

  assign mode    = mode_q;
  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=4, DB_CYCLES=3).
// Every key change is matched against a queue of expected codes, each
// with the expected number of cycles since the previous change (0 = any).
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_run;
  logic       btn_mode;
  logic [1:0] sw_speed;
  logic [3:0] key;
  logic [1:0] mode;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] key;
    int         gap;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        sb_e;
  logic [3:0] prev_key = 4'd14;
  int         cyc = 0;
  int         last_chg = 0;

  int bseq[19] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5};

  led_seq_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_mode (btn_mode),
    .sw_speed (sw_speed),
    .key      (key),
    .mode     (mode),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [3:0] k, input int g);
    sb_t e;
    e.key = k;
    e.gap = g;
    sb_q.push_back(e);
  endfunction

  task automatic press_run(input int n);
    btn_run = 1'b1;
    repeat (n) @(negedge clk);
    btn_run = 1'b0;
  endtask

  task automatic press_mode(input int n);
    btn_mode = 1'b1;
    repeat (n) @(negedge clk);
    btn_mode = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (key !== prev_key) begin
      if (sb_q.size() == 0) begin
        check("key_extra", key, prev_key);
      end else begin
        sb_e = sb_q.pop_front();
        check("key_seq", key, sb_e.key);
        if (sb_e.gap != 0) check("key_gap", cyc - last_chg, sb_e.gap);
      end
      last_chg = cyc;
      prev_key = key;
    end
  end

  initial begin
    btn_run  = 1'b0;
    btn_mode = 1'b0;
    sw_speed = 2'd3;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key", key, 14);
    check("rst_mode", mode, 0);
    check("rst_running", running, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // SHL stepping at full speed, then pause.
    push(4'd0, 0);
    for (int k = 1; k <= 9; k++) push(4'(k % 8), 4);
    press_run(5);
    repeat (15) @(negedge clk);
    check("run_running", running, 1);
    check("run_mode", mode, 0);
    repeat (18) @(negedge clk);
    press_run(5);
    repeat (7) @(negedge clk);
    check("pause_running", running, 0);
    check("drain_shl", sb_q.size(), 0);
    repeat (10) @(negedge clk);

    // Resume from held prescaler count, then slow-to-fast speed switch.
    push(4'd2, 0);
    push(4'd3, 4);
    press_run(5);
    repeat (3) @(negedge clk);
    check("resume_hold", key, 1);
    @(negedge clk);
    check("resume_key", key, 2);
    check("resume_running", running, 1);
    repeat (4) @(negedge clk);
    sw_speed = 2'd0;
    push(4'd4, 11);
    push(4'd5, 4);
    push(4'd6, 4);
    push(4'd14, 0);
    repeat (9) @(negedge clk);
    sw_speed = 2'd3;
    repeat (2) @(negedge clk);
    check("speed_switch_key", key, 4);

    // Reset mid-run at key 6 with the run button held across release.
    repeat (8) @(negedge clk);
    #1;
    rst_n   = 1'b0;
    btn_run = 1'b1;
    #1;
    check("midrst_key", key, 14);
    check("midrst_mode", mode, 0);
    check("midrst_running", running, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("held_running", running, 0);
    check("drain_rst", sb_q.size(), 0);
    btn_run = 1'b0;
    repeat (6) @(negedge clk);

    // Glitch rejection, BOUNCE sweep, BLINK, mode change, coincident presses.
    btn_run = 1'b1;
    repeat (2) @(negedge clk);
    btn_run = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_running", running, 0);
    press_mode(5);
    repeat (5) @(negedge clk);
    press_mode(5);
    repeat (8) @(negedge clk);
    check("mode_bounce", mode, 2);
    push(4'd0, 0);
    foreach (bseq[i]) push(4'(bseq[i]), 4);
    push(4'd14, 4);
    push(4'd5, 4);
    push(4'd14, 4);
    push(4'd5, 2);
    push(4'd6, 2);
    push(4'd7, 4);
    push(4'd0, 4);
    press_run(4);
    repeat (16) @(negedge clk);
    check("press4_running", running, 1);
    repeat (58) @(negedge clk);
    press_mode(5);
    repeat (2) @(negedge clk);
    check("mode_blink", mode, 3);
    repeat (5) @(negedge clk);
    press_mode(5);
    repeat (2) @(negedge clk);
    check("mode_shl", mode, 0);
    check("blink_exit_key", key, 5);
    repeat (3) @(negedge clk);
    btn_run  = 1'b1;
    btn_mode = 1'b1;
    repeat (5) @(negedge clk);
    btn_run  = 1'b0;
    btn_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("both_running", running, 0);
    check("both_mode", mode, 1);
    repeat (10) @(negedge clk);
    check("drain_final", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, base step period in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter DB_CYCLES, default 500000, debounce stable-time in clk cycles; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_run  input  1  raw run/pause pushbutton, active-high, asynchronous to clk.
REQ-006 btn_mode  input  1  raw mode-select pushbutton, active-high, asynchronous to clk.
REQ-007 sw_speed  input  2  step rate select; sampled every cycle.
REQ-008 key  output  4  registered code driving the 8-LED one-hot decoder; only values 0-7 and 14 (all off).
REQ-009 mode  output  2  current pattern mode, registered.
REQ-010 running  output  1  high in state RUN only.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the debounced level changes only after the synchronized input has held the new value for DB_CYCLES consecutive cycles.
REQ-012 A debounced 0->1 transition SHALL produce exactly one 1-cycle pulse (run_p / mode_p); hold or release produces none.
REQ-013 The prescaler SHALL count 0..TERM and emit a 1-cycle tick at TERM, where TERM = TICK_DIV*M-1 and M = 8/4/2/1 for sw_speed = 0/1/2/3.
REQ-014 The prescaler SHALL compare count >= TERM so that lowering sw_speed mid-count ticks on the next cycle, never overruns.
REQ-015 The prescaler SHALL run only in RUN; it SHALL clear on entering RUN from IDLE and hold its value in PAUSE.
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE; run_p moves IDLE->RUN, RUN->PAUSE, PAUSE->RUN; no other transitions.
REQ-017 Entering RUN from IDLE SHALL set pos = 0, dir = up, blink phase = on.
REQ-018 On each tick in RUN, pos[2:0] SHALL update per mode: SHL pos+1 (7 wraps to 0); SHR pos-1 (0 wraps to 7); BOUNCE step in dir, reversing dir when the next step would leave 0..7 (sequence ...6,7,6,...,1,0,1...); BLINK pos unchanged, blink phase toggles.
REQ-019 mode_p SHALL cycle mode SHL->SHR->BOUNCE->BLINK->SHL in any state; pos is kept; blink phase is forced on; dir is set up for SHL and down for SHR, and is kept for BOUNCE and BLINK.
REQ-020 When run_p and mode_p coincide, both SHALL take effect in the same cycle.
REQ-021 When a mode change coincides with a tick, the tick SHALL use the old mode and the new mode applies from the next tick.
REQ-022 key SHALL be 14 in IDLE, and 14 in BLINK with blink phase off; otherwise key SHALL be {1'b0,pos}; key is registered, updating one cycle after the state or pos change.

Reset
REQ-023 While rst_n = 0, outputs SHALL be key = 14, mode = SHL (0), running = 0; internal state SHALL be FSM = IDLE, pos = 0, dir = up, prescaler = 0, debounced levels = 0, synchronizers = 0.
REQ-024 Reset assertion mid-operation SHALL force all reset values immediately; after release no pulse SHALL be emitted for a button already held unless it is seen low then high again.

Structure
REQ-025 Package led_seq_pkg SHALL hold the mode encoding (SHL=0, SHR=1, BOUNCE=2, BLINK=3), the FSM state encoding, and the constant KEY_OFF = 14.
REQ-026 The synchronizer, debouncer and edge pulse SHALL form sub-module led_btn_debounce (parameter DB_CYCLES), instantiated twice.

Verification (bench: TICK_DIV=4, DB_CYCLES=3)
REQ-027 Reset, then a clean btn_run press, sw_speed=3 -> running=1; key steps 0,1,2,...,7,0 every 4 cycles in mode SHL.
REQ-028 btn_run glitch high for 2 cycles -> no state change, key stays 14; a 4-cycle press -> exactly one run_p.
REQ-029 RUN in BOUNCE from pos 0 for 16 ticks -> key 1,2,...,7,6,5,...,0,1,2.
REQ-030 RUN in BLINK at pos 5 -> key alternates 5,14,5,14 per tick; a mode press -> mode=SHL, key 5 then 6 on the next tick.
REQ-031 sw_speed=0 with prescaler at count 10, switch to 3 -> tick on the next cycle; a second press in PAUSE -> key frozen and resumes from the held count.
REQ-032 rst_n low mid-RUN at key=6 -> key=14, mode=0, running=0 at once; btn held across release -> no run_p.
